// File: rtl/control_sequencer_pkg.sv
// Purpose: shared encodings for the control sequencer (states, control-word fields, constants).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package control_sequencer_pkg;

  // Control-word width and layout, MSB first.
  localparam int CW_W = 33;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EX0   = 2'b01,
    ST_EX1   = 2'b10,
    ST_EX2   = 2'b11
  } state_t;

  localparam int CW_ALU_ENABLE      = 32;
  localparam int CW_ALU_BS          = 31;
  localparam int CW_ALU_FS_LSB      = 26;  // 5 bits
  localparam int CW_RF_B_ENABLE     = 25;
  localparam int CW_SA_LSB          = 20;  // 5 bits
  localparam int CW_SB_LSB          = 15;  // 5 bits
  localparam int CW_WA_LSB          = 10;  // 5 bits
  localparam int CW_REG_W           = 9;
  localparam int CW_RAM_ENABLE      = 8;
  localparam int CW_RAM_W           = 7;
  localparam int CW_PC_ENABLE       = 6;
  localparam int CW_PC_FS_LSB       = 4;   // 2 bits
  localparam int CW_PC_INPUT_SELECT = 3;
  localparam int CW_STATUS_LOAD     = 2;
  localparam int CW_NS_LSB          = 0;   // 2 bits

  // Fetch cycle only advances the PC: pc_fs = 2'b01, everything else zero.
  localparam logic [CW_W-1:0] FETCH_WORD = 33'd1 << CW_PC_FS_LSB;

  // Fields that commit architectural side effects; hold forces them off.
  localparam logic [CW_W-1:0] HOLD_KILL_MASK = (33'd1 << CW_REG_W)
                                             | (33'd1 << CW_RAM_W)
                                             | (33'd3 << CW_PC_FS_LSB)
                                             | (33'd1 << CW_STATUS_LOAD);

endpackage

// File: rtl/control_sequencer_watchdog.sv
// Purpose: counts consecutive non-held EXEC cycles and trips after WDOG_LIMIT of them; sticky fault.
// Latency: trip is combinational in the cycle the limit is reached; fault registers on that edge.
// Backpressure: hold freezes the count; no trip can fire while held.
// Ports: clock/reset (sync, active-high); exec_active = sequencer is in an EXEC state;
//        hold = sequencer frozen; trip = force FETCH at next edge; fault = sticky watchdog flag.
module seq_watchdog #(
  parameter int WDOG_LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic exec_active,
  input  logic hold,
  output logic trip,
  output logic fault
);

  localparam int CNT_W = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);

  logic [CNT_W-1:0] count;

  // The count holds the number of EXEC cycles already completed, so this cycle is the
  // WDOG_LIMIT-th one when count == WDOG_LIMIT-1.
  assign trip = exec_active && !hold && (count == CNT_W'(WDOG_LIMIT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      fault <= 1'b0;
    end else if (!hold) begin
      if (!exec_active || trip) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
      if (trip) begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Purpose: FETCH/EXEC sequencer owning ir/state/status and muxing the datapath control word.
// Latency: ctrl_word and ir_load are combinational; ir/state/status update on the next edge.
// Backpressure: hold freezes all state and suppresses writes; imem_ready=0 stalls in FETCH.
// Ports: clock, reset (sync active-high); instr_in/imem_ready from instruction memory;
//        dec_word/status_in from decoders and ALU; ctrl_word to datapath; ir/state/status
//        to decoders; ir_load strobe; fault only when built with SEQ_WATCHDOG_EN.
// Build option: define SEQ_WATCHDOG_EN to add the EXEC-length watchdog and the fault port.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int WDOG_LIMIT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instr_in,
  input  logic            imem_ready,
  input  logic [CW_W-1:0] dec_word,
  input  logic [4:0]      status_in,
  input  logic            hold,
  output logic [CW_W-1:0] ctrl_word,
  output logic [31:0]     ir,
  output logic [1:0]      state,
  output logic [4:0]      status,
  output logic            ir_load
`ifdef SEQ_WATCHDOG_EN
  ,
  output logic            fault
`endif
);

  state_t      state_q, state_nxt;
  logic [31:0] ir_q, ir_nxt;
  logic [4:0]  status_q, status_nxt;
  logic        wdog_trip;

`ifdef SEQ_WATCHDOG_EN
  seq_watchdog #(
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_watchdog (
    .clock       (clock),
    .reset       (reset),
    .exec_active (state_q != ST_FETCH),
    .hold        (hold),
    .trip        (wdog_trip),
    .fault       (fault)
  );
`else
  // No watchdog: EXEC may run as long as the decoders keep NS non-zero. The parameter is
  // kept so both builds present the same instance interface.
  assign wdog_trip = 1'b0;
  if (WDOG_LIMIT < 1) begin : g_wdog_limit_unused
  end
`endif

  always_comb begin
    ctrl_word  = '0;
    ir_load    = 1'b0;
    state_nxt  = state_q;
    ir_nxt     = ir_q;
    status_nxt = status_q;

    if (state_q == ST_FETCH) begin
      if (imem_ready) begin
        ctrl_word = FETCH_WORD;
        if (!hold) begin
          ir_load   = 1'b1;
          ir_nxt    = instr_in;
          state_nxt = ST_EX0;
        end
      end
    end else begin
      ctrl_word = dec_word;
      if (!hold) begin
        state_nxt = state_t'(dec_word[CW_NS_LSB +: 2]);
        if (dec_word[CW_STATUS_LOAD]) begin
          status_nxt = status_in;
        end
        if (wdog_trip) begin
          state_nxt = ST_FETCH;
        end
      end
    end

    if (hold) begin
      ctrl_word = ctrl_word & ~HOLD_KILL_MASK;
    end

    // Reset abandons whatever is in flight: nothing reaches the datapath this cycle.
    if (reset) begin
      ctrl_word = '0;
      ir_load   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_nxt;
      ir_q     <= ir_nxt;
      status_q <= status_nxt;
    end
  end

  assign state  = state_q;
  assign ir     = ir_q;
  assign status = status_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose: self-checking bench for control_sequencer (directed table, watchdog run, random vs model).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_control_sequencer;

  localparam int LIMIT = 15;

  logic        clock;
  logic        reset;
  logic [31:0] instr_in;
  logic        imem_ready;
  logic [32:0] dec_word;
  logic [4:0]  status_in;
  logic        hold;
  logic [32:0] ctrl_word;
  logic [31:0] ir;
  logic [1:0]  state;
  logic [4:0]  status;
  logic        ir_load;
`ifdef SEQ_WATCHDOG_EN
  logic        fault;
`endif

  control_sequencer #(
    .WDOG_LIMIT (LIMIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .instr_in   (instr_in),
    .imem_ready (imem_ready),
    .dec_word   (dec_word),
    .status_in  (status_in),
    .hold       (hold),
    .ctrl_word  (ctrl_word),
    .ir         (ir),
    .state      (state),
    .status     (status),
    .ir_load    (ir_load)
`ifdef SEQ_WATCHDOG_EN
    ,
    .fault      (fault)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; combinational outputs are sampled 2 units later.
  task automatic drive(input logic r, input logic rdy, input logic h, input logic [31:0] ins,
                       input logic [32:0] dw, input logic [4:0] sti);
    reset = r; imem_ready = rdy; hold = h; instr_in = ins; dec_word = dw; status_in = sti;
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        rst, rdy, hld;
    logic [31:0] ins;
    logic [32:0] dw;
    logic [4:0]  sti;
    logic [32:0] e_ctrl;
    logic        e_ld;
    logic [1:0]  e_state;
    logic [31:0] e_ir;
    logic [4:0]  e_status;
  } vec_t;

  vec_t vt[13];

  // Behavioural reference state.
  int          m_state;
  logic [31:0] m_ir;
  logic [4:0]  m_status;
  int          m_run;
  bit          m_fault;

  // reg_w | ram_w | pc_fs | status_load
  localparam logic [32:0] SIDE_EFFECTS = 33'h0_0000_02B4;

  initial begin
    logic [32:0] e_ctrl;
    logic        e_ld;
    logic        r, rdy, h;
    logic [31:0] ins;
    logic [32:0] dw;
    logic [4:0]  sti;

    reset = 1'b1; imem_ready = 1'b0; hold = 1'b0;
    instr_in = '0; dec_word = '0; status_in = '0;
    repeat (2) @(posedge clock);
    #1;

    //          rst rdy hld ins            dw              sti    e_ctrl          ld st  e_ir           e_status
    vt[0]  = '{1, 1, 0, 32'h0000_0123, 33'h1_FFFF_FFFF, 5'h1F, 33'h0_0000_0000, 0, 0, 32'h0000_0000, 5'h00};
    vt[1]  = '{0, 1, 0, 32'h9100_0421, 33'h1_FFFF_FFFF, 5'h1F, 33'h0_0000_0010, 1, 1, 32'h9100_0421, 5'h00};
    vt[2]  = '{0, 0, 0, 32'h0000_0000, 33'h0_8000_0204, 5'h15, 33'h0_8000_0204, 0, 0, 32'h9100_0421, 5'h15};
    vt[3]  = '{0, 0, 0, 32'hDEAD_BEEF, 33'h1_FFFF_FFFF, 5'h00, 33'h0_0000_0000, 0, 0, 32'h9100_0421, 5'h15};
    vt[4]  = '{0, 0, 0, 32'hDEAD_BEEF, 33'h1_FFFF_FFFF, 5'h00, 33'h0_0000_0000, 0, 0, 32'h9100_0421, 5'h15};
    vt[5]  = '{0, 0, 0, 32'hDEAD_BEEF, 33'h1_FFFF_FFFF, 5'h00, 33'h0_0000_0000, 0, 0, 32'h9100_0421, 5'h15};
    vt[6]  = '{0, 1, 0, 32'h0000_00A5, 33'h0_0000_0000, 5'h00, 33'h0_0000_0010, 1, 1, 32'h0000_00A5, 5'h15};
    vt[7]  = '{0, 0, 1, 32'h0000_0000, 33'h1_0000_03B6, 5'h00, 33'h1_0000_0102, 0, 1, 32'h0000_00A5, 5'h15};
    vt[8]  = '{0, 0, 0, 32'h0000_0000, 33'h1_0000_03B6, 5'h00, 33'h1_0000_03B6, 0, 2, 32'h0000_00A5, 5'h00};
    vt[9]  = '{0, 0, 0, 32'h0000_0000, 33'h0_0000_0006, 5'h0A, 33'h0_0000_0006, 0, 2, 32'h0000_00A5, 5'h0A};
    vt[10] = '{1, 1, 1, 32'h0000_FFFF, 33'h1_FFFF_FFFF, 5'h1F, 33'h0_0000_0000, 0, 0, 32'h0000_0000, 5'h00};
    vt[11] = '{0, 1, 1, 32'h0000_0077, 33'h0_0000_0000, 5'h00, 33'h0_0000_0000, 0, 0, 32'h0000_0000, 5'h00};
    vt[12] = '{0, 1, 0, 32'h1234_5678, 33'h0_0000_0000, 5'h00, 33'h0_0000_0010, 1, 1, 32'h1234_5678, 5'h00};

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].rst, vt[i].rdy, vt[i].hld, vt[i].ins, vt[i].dw, vt[i].sti);
      chk($sformatf("vec%0d ctrl_word", i), ctrl_word, vt[i].e_ctrl);
      chk($sformatf("vec%0d ir_load", i), 33'(ir_load), 33'(vt[i].e_ld));
      tick();
      chk($sformatf("vec%0d state", i), 33'(state), 33'(vt[i].e_state));
      chk($sformatf("vec%0d ir", i), 33'(ir), 33'(vt[i].e_ir));
      chk($sformatf("vec%0d status", i), 33'(status), 33'(vt[i].e_status));
`ifdef SEQ_WATCHDOG_EN
      if (vt[i].rst) chk($sformatf("vec%0d fault", i), 33'(fault), 33'd0);
`endif
    end

    // Watchdog run: NS=01 forever from a fresh EXEC entry.
    for (int i = 1; i <= LIMIT + 5; i++) begin
      drive(0, 0, 0, 32'h0, 33'h0_0000_0001, 5'h0);
      tick();
`ifdef SEQ_WATCHDOG_EN
      if (i == LIMIT - 1) begin
        chk("wdog state before limit", 33'(state), 33'd1);
        chk("wdog fault before limit", 33'(fault), 33'd0);
      end
      if (i == LIMIT) begin
        chk("wdog state at limit", 33'(state), 33'd0);
        chk("wdog fault at limit", 33'(fault), 33'd1);
      end
      if (i == LIMIT + 5) chk("wdog fault sticky", 33'(fault), 33'd1);
`else
      if (i == LIMIT || i == LIMIT + 5) chk($sformatf("no-wdog state run%0d", i), 33'(state), 33'd1);
`endif
    end

    // Random phase against the behavioural model; begins with a reset cycle.
    m_state = 0; m_ir = '0; m_status = '0; m_run = 0; m_fault = 0;
    for (int c = 0; c < 3000; c++) begin
      r   = (c == 0) || ($urandom_range(0, 63) == 0);
      rdy = $urandom_range(0, 1) == 1;
      h   = $urandom_range(0, 3) == 0;
      ins = $urandom;
      sti = 5'($urandom);
      dw  = {1'($urandom), $urandom};
      if ($urandom_range(0, 15) == 0) dw[1:0] = 2'b00;
      else dw[1:0] = 2'($urandom_range(1, 3));
      drive(r, rdy, h, ins, dw, sti);

      if (r) begin
        e_ctrl = '0; e_ld = 1'b0;
      end else if (m_state == 0) begin
        e_ld   = rdy && !h;
        e_ctrl = e_ld ? 33'h0_0000_0010 : 33'h0;
      end else begin
        e_ld   = 1'b0;
        e_ctrl = h ? (dw & ~SIDE_EFFECTS) : dw;
      end
      chk("rand ctrl_word", ctrl_word, e_ctrl);
      chk("rand ir_load", 33'(ir_load), 33'(e_ld));

      if (r) begin
        m_state = 0; m_ir = '0; m_status = '0; m_run = 0; m_fault = 0;
      end else if (!h) begin
        if (m_state == 0) begin
          if (rdy) begin
            m_ir = ins; m_state = 1; m_run = 0;
          end
        end else begin
          m_run++;
          if (dw[2]) m_status = sti;
          m_state = int'(dw[1:0]);
`ifdef SEQ_WATCHDOG_EN
          if (m_run >= LIMIT) begin
            m_state = 0; m_fault = 1;
          end
`endif
        end
      end

      tick();
      chk("rand state", 33'(state), 33'(m_state));
      chk("rand ir", 33'(ir), 33'(m_ir));
      chk("rand status", 33'(status), 33'(m_status));
`ifdef SEQ_WATCHDOG_EN
      chk("rand fault", 33'(fault), 33'(m_fault));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide parameter WDOG_LIMIT, default 15: maximum number of consecutive execute-state cycles before the watchdog trips.
REQ-002 SHALL provide clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide instr_in  input  32  instruction word from instruction memory.
REQ-005 SHALL provide imem_ready  input  1  instr_in valid this cycle.
REQ-006 SHALL provide dec_word  input  33  control word from the per-type decoder for the current ir/state/status.
REQ-007 SHALL provide status_in  input  5  ALU status flags.
REQ-008 SHALL provide hold  input  1  freeze the sequencer this cycle.
REQ-009 SHALL provide ctrl_word  output  33  control word to the datapath.
REQ-010 SHALL provide ir  output  32  instruction register, to the decoders.
REQ-011 SHALL provide state  output  2  current state, to the decoders.
REQ-012 SHALL provide status  output  5  registered status flags, to the decoders.
REQ-013 SHALL provide ir_load  output  1  IR capture strobe.
REQ-014 SHALL provide fault  output  1  sticky watchdog fault (present only with SEQ_WATCHDOG_EN).

Function
REQ-015 SHALL use the 33-bit control word layout, MSB first: alu_enable, alu_bs, alu_fs[4:0], rf_b_enable, sa[4:0], sb[4:0], wa[4:0], reg_w, ram_enable, ram_w, pc_enable, pc_fs[1:0], pc_input_select, status_load, NS[1:0].
REQ-016 SHALL treat state 2'b00 as FETCH; states 2'b01, 2'b10 and 2'b11 are EXEC states owned by the decoders.
REQ-017 In FETCH, ctrl_word SHALL be all zeros except pc_fs=2'b01 when imem_ready=1; dec_word is ignored.
REQ-018 In FETCH with imem_ready=1 and hold=0, the sequencer SHALL assert ir_load combinationally, load ir<=instr_in, and move to state 2'b01 on the next edge.
REQ-019 In FETCH with imem_ready=0, the sequencer SHALL stay in FETCH with ir_load=0 and pc_fs=2'b00.
REQ-020 In EXEC, ctrl_word SHALL equal dec_word combinationally (zero latency).
REQ-021 In EXEC, the next state SHALL be dec_word NS, where NS=2'b00 returns to FETCH.
REQ-022 In EXEC, status SHALL load status_in on the edge when dec_word status_load=1 and hold=0; otherwise status holds.
REQ-023 hold=1 SHALL freeze state, ir, status and the watchdog counter, and SHALL force reg_w, ram_w and status_load to 0 and pc_fs to 2'b00 in ctrl_word.
REQ-024 ir SHALL change only on an ir_load edge.

Reset
REQ-025 On reset, the sequencer SHALL set state=FETCH, ir=0, status=0, fault=0 and watchdog count=0 at the clock edge.
REQ-026 While reset=1, ctrl_word SHALL be all zeros and ir_load SHALL be 0.
REQ-027 reset SHALL take priority over hold, imem_ready and watchdog.
REQ-028 reset asserted mid-EXEC SHALL abandon the instruction with no writes issued in that cycle.

Configuration
REQ-029 With SEQ_WATCHDOG_EN defined, a counter SHALL increment on each non-held EXEC cycle and clear in FETCH.
REQ-030 With SEQ_WATCHDOG_EN defined, when the counter reaches WDOG_LIMIT in EXEC, the next state SHALL be forced to FETCH and fault SHALL set; fault stays set until reset.
REQ-031 Without SEQ_WATCHDOG_EN, the counter and fault port SHALL be absent, and EXEC may persist indefinitely per NS.

Structure
REQ-032 The shared package SHALL hold state encodings (ST_FETCH, ST_EX0..ST_EX2), control-word field bit positions, the control-word width (33), and the fetch-word constant.
REQ-033 The watchdog SHALL be one sub-module, seq_watchdog, instantiated only under SEQ_WATCHDOG_EN.

Verification
REQ-034 Reset then imem_ready=1 with instr_in=32'h91000421 SHALL give ir_load=1 and pc_fs=01 that cycle, then ir=32'h91000421 and state=01.
REQ-035 In EXEC with dec_word NS=00, status_load=1 and status_in=5'b10101 SHALL give ctrl_word==dec_word, status=10101 next cycle, and state=00.
REQ-036 imem_ready=0 for 3 cycles SHALL keep state=00, ir_load=0 and pc_fs=00 throughout; ir is unchanged.
REQ-037 hold=1 in EXEC with dec_word reg_w=1 SHALL give reg_w=0 in ctrl_word, and state and status unchanged.
REQ-038 dec_word NS=01 held constant with WDOG_LIMIT=15 SHALL force state=00 after 15 EXEC cycles with fault=1 (macro on); with the macro off, state stays 01.
REQ-039 reset asserted in state 10 together with hold=1 SHALL give state=00, ir=0 and status=0 next cycle, with ctrl_word all zeros while reset is high.
